// File: rtl/judge_score_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : judge_score_sequencer
//  Description : Two-lane judgement scoring controller. A game FSM gates the
//                beats. Stage A turns each beat into points and combo, and
//                stage B adds the points to a saturating total score.
//  Revision    : 1.0  initial release
// ============================================================================
module judge_score_sequencer #(
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 10,
    parameter int PERFECT_PTS = 100,
    parameter int GOOD_PTS    = 50,
    parameter int COMBO_TH    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               game_end,
    input  logic               judge_valid,
    input  logic [1:0]         judgement_up,
    input  logic [1:0]         judgement_down,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               score_valid,
    output logic               playing,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COMBO_W-1:0] c_COMBO_MAX = '1;
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;
    localparam logic [SCORE_W:0]   c_PTS_MAX   = '1;

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;
    logic [COMBO_W-1:0] r_max_combo;
    logic [SCORE_W:0]   r_beat_pts;
    logic               r_a_valid;
    logic               r_score_valid;
    logic               r_playing;
    logic               r_done;

    function automatic logic [COMBO_W-1:0] f_next_combo(input logic [1:0] j,
                                                        input logic [COMBO_W-1:0] c);
        logic [COMBO_W-1:0] n;
        case (j)
            2'b00, 2'b01: n = (c == c_COMBO_MAX) ? c : c + 1'b1;
            2'b10:        n = '0;
            default:      n = c;
        endcase
        return n;
    endfunction

    // Points are clamped to the beat-points width; any clamp is hidden by the
    // score saturation in stage B.
    function automatic logic [SCORE_W:0] f_points(input logic [1:0] j,
                                                  input logic [COMBO_W-1:0] c);
        logic [31:0] base;
        case (j)
            2'b00:   base = 32'(PERFECT_PTS);
            2'b01:   base = 32'(GOOD_PTS);
            default: base = 32'd0;
        endcase
        if (32'(c) >= 32'(COMBO_TH))
            base = base << 1;
        return (base > 32'(c_PTS_MAX)) ? c_PTS_MAX : base[SCORE_W:0];
    endfunction

    logic               w_accept;
    logic [COMBO_W-1:0] w_combo_up;
    logic [COMBO_W-1:0] w_combo_dn;
    logic [COMBO_W-1:0] w_max_up;
    logic [COMBO_W-1:0] w_max_dn;
    logic [SCORE_W+1:0] w_pts_sum;
    logic [SCORE_W:0]   w_beat_pts;
    logic [SCORE_W+1:0] w_score_sum;
    logic [SCORE_W-1:0] w_score_next;

    // The down lane sees the combo left behind by the up lane.
    always_comb begin
        w_accept     = judge_valid && (r_state == S_PLAY);
        w_combo_up   = f_next_combo(judgement_up, r_combo);
        w_combo_dn   = f_next_combo(judgement_down, w_combo_up);
        w_max_up     = (w_combo_up > r_max_combo) ? w_combo_up : r_max_combo;
        w_max_dn     = (w_combo_dn > w_max_up) ? w_combo_dn : w_max_up;
        w_pts_sum    = {1'b0, f_points(judgement_up, r_combo)}
                     + {1'b0, f_points(judgement_down, w_combo_up)};
        w_beat_pts   = w_pts_sum[SCORE_W+1] ? c_PTS_MAX : w_pts_sum[SCORE_W:0];
        w_score_sum  = {2'b00, r_score} + {1'b0, r_beat_pts};
        w_score_next = (w_score_sum > {2'b00, c_SCORE_MAX}) ? c_SCORE_MAX
                                                            : w_score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_score       <= '0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_beat_pts    <= '0;
            r_a_valid     <= 1'b0;
            r_score_valid <= 1'b0;
            r_playing     <= 1'b0;
            r_done        <= 1'b0;
        end else if (start) begin
            // Restart wins over everything, including a beat in flight.
            r_state       <= S_PLAY;
            r_score       <= '0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_beat_pts    <= '0;
            r_a_valid     <= 1'b0;
            r_score_valid <= 1'b0;
            r_playing     <= 1'b1;
            r_done        <= 1'b0;
        end else begin
            r_a_valid     <= w_accept;
            r_score_valid <= r_a_valid;
            if (r_a_valid)
                r_score <= w_score_next;
            if (w_accept) begin
                r_combo     <= w_combo_dn;
                r_max_combo <= w_max_dn;
                r_beat_pts  <= w_beat_pts;
            end
            case (r_state)
                S_PLAY: begin
                    if (game_end) begin
                        r_state   <= S_DRAIN;
                        r_playing <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign score       = r_score;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;
    assign score_valid = r_score_valid;
    assign playing     = r_playing;
    assign done        = r_done;

endmodule
`default_nettype wire
